// File: rtl/rv_pkg.sv
// Shared fetch-path constants and the fetch-stage state encoding.
package rv_pkg;

  localparam int XLEN    = 64;
  localparam int INST_W  = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam int PC_STEP = 4;

  typedef enum logic [0:0] {
    FS_RUN   = 1'b0,
    FS_DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head visible combinationally, push visible next cycle.
// Push is ignored when full and pop when empty; flush and reset empty it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: in-order imem requests, buffered responses to decode, redirect flush/drain.
// Fire-to-inst_valid is at least 2 cycles; requests stall when in-flight + buffered reaches QDEPTH.
module fetch_stage #(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [XLEN-1:0]            pc_cur,
  output logic [XLEN-1:0]            pc_next,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_target,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [rv_pkg::INST_W-1:0]  imem_resp_data,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [rv_pkg::INST_W-1:0]  inst_data,
  output logic [XLEN-1:0]            inst_pc
);

  import rv_pkg::*;

  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } ibuf_entry_t;

  fetch_state_t  state;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] remaining;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] pcq_count;
  logic [CW:0]   occupancy;
  logic          fire;
  logic          accept_resp;
  logic          buf_pop;
  logic [XLEN-1:0] resp_pc;
  ibuf_entry_t   buf_in;
  ibuf_entry_t   buf_head;

  // Occupancy comes from registered state only, so a same-cycle pop never frees a slot.
  assign occupancy      = {1'b0, inflight} + {1'b0, buf_count};
  assign imem_req_valid = !reset && (state == FS_RUN) && !redirect_valid &&
                          (occupancy < (CW+1)'(QDEPTH));
  assign fire           = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc_cur;

  assign accept_resp = !reset && (state == FS_RUN) && !redirect_valid && imem_resp_valid;
  assign remaining   = inflight - CW'(imem_resp_valid);

  always_comb begin
    pc_next = pc_cur;
    if (reset) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = redirect_target & ~XLEN'(2'b11);
    end else if (fire) begin
      pc_next = pc_cur + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FS_RUN;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding after this cycle's response belongs to the old path.
      inflight <= remaining;
      drop_cnt <= remaining;
      state    <= (remaining != '0) ? FS_DRAIN : FS_RUN;
    end else begin
      case (state)
        FS_RUN: begin
          inflight <= inflight + CW'(fire) - CW'(imem_resp_valid);
        end
        FS_DRAIN: begin
          if (imem_resp_valid) begin
            inflight <= inflight - CW'(1);
            drop_cnt <= drop_cnt - CW'(1);
            if (drop_cnt == CW'(1)) state <= FS_RUN;
          end
        end
        default: state <= FS_RUN;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (QDEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (fire),
    .push_data (pc_cur),
    .pop       (accept_resp),
    .pop_data  (resp_pc),
    .count     (pcq_count)
  );

  assign buf_in.inst = imem_resp_data;
  assign buf_in.pc   = resp_pc;
  assign buf_pop     = inst_valid && inst_ready && !redirect_valid;

  fetch_fifo #(
    .WIDTH (INST_W + XLEN),
    .DEPTH (QDEPTH)
  ) u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (accept_resp),
    .push_data (buf_in),
    .pop       (buf_pop),
    .pop_data  (buf_head),
    .count     (buf_count)
  );

  assign inst_valid = !reset && (buf_count != '0);
  assign inst_data  = buf_head.inst;
  assign inst_pc    = buf_head.pc;

  // While running, the PC FIFO holds exactly the outstanding requests.
  a_pcq_tracks_inflight: assert property (
    @(posedge clk) disable iff (reset) (state == FS_RUN) |-> (pcq_count == inflight)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then random traffic against a queue-based model.
module tb_fetch_stage;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_cur;
  logic [63:0] pc_next;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(64), .RESET_PC(64'h0), .QDEPTH(QD)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
  );

  // Outstanding memory requests tagged with the redirect epoch they were issued in.
  typedef struct { logic [63:0] addr; int epoch; int issue_cyc; } req_t;
  typedef struct { logic [31:0] data; logic [63:0] pc; } ent_t;
  typedef struct {
    logic rst; logic redir; logic [63:0] tgt; logic irdy; logic mrdy; logic men;
    logic exp_rv; logic [63:0] exp_pn; logic exp_iv; logic [63:0] exp_ipc;
  } vec_t;

  req_t mem_q[$];
  ent_t buf_q[$];
  vec_t vecs[$];
  int   epoch = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic resp_en;
  logic s_rv, s_iv;
  logic [63:0] s_pn, s_ipc;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {a[15:0], ~a[31:16]} ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are checked mid-cycle, model advances.
  task automatic step();
    int   stale;
    logic exp_rv, exp_iv, fire, deliver;
    logic [63:0] exp_pn;
    req_t r;
    ent_t e;

    if (resp_en && mem_q.size() > 0 && mem_q[0].issue_cyc < cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst_of(mem_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end

    @(negedge clk);
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    if (reset) begin
      exp_rv = 1'b0;
      exp_pn = 64'h0;
    end else begin
      exp_rv = !redirect_valid && (stale == 0) && (mem_q.size() + buf_q.size() < QD);
      if (redirect_valid)                exp_pn = {redirect_target[63:2], 2'b00};
      else if (exp_rv && imem_req_ready) exp_pn = pc_cur + 64'd4;
      else                               exp_pn = pc_cur;
    end
    exp_iv = !reset && (buf_q.size() > 0);

    s_rv = imem_req_valid; s_pn = pc_next; s_iv = inst_valid; s_ipc = inst_pc;
    chk("req_valid", cyc, 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", cyc, imem_req_addr, pc_cur);
    chk("pc_next", cyc, pc_next, exp_pn);
    chk("inst_valid", cyc, 64'(inst_valid), 64'(exp_iv));
    if (exp_iv) begin
      chk("inst_pc", cyc, inst_pc, buf_q[0].pc);
      chk("inst_data", cyc, 64'(inst_data), 64'(buf_q[0].data));
    end

    fire = exp_rv && imem_req_ready;
    if (reset) begin
      mem_q.delete();
      buf_q.delete();
    end else begin
      deliver = 1'b0;
      if (imem_resp_valid) begin
        r = mem_q.pop_front();
        if (!redirect_valid && r.epoch == epoch) begin
          deliver = 1'b1;
          e.data  = inst_of(r.addr);
          e.pc    = r.addr;
        end
      end
      if (!redirect_valid && inst_ready && buf_q.size() > 0) void'(buf_q.pop_front());
      if (deliver) buf_q.push_back(e);
      if (redirect_valid) begin
        buf_q.delete();
        epoch++;
      end
      if (fire) mem_q.push_back('{pc_cur, epoch, cyc});
    end

    @(posedge clk);
    #1;
    cyc++;
    pc_cur = exp_pn;
  endtask

  function automatic vec_t v(input logic rst, input logic redir, input logic [63:0] tgt,
                             input logic irdy, input logic mrdy, input logic men,
                             input logic erv, input logic [63:0] epn,
                             input logic eiv, input logic [63:0] eipc);
    vec_t t;
    t.rst = rst; t.redir = redir; t.tgt = tgt; t.irdy = irdy; t.mrdy = mrdy; t.men = men;
    t.exp_rv = erv; t.exp_pn = epn; t.exp_iv = eiv; t.exp_ipc = eipc;
    return t;
  endfunction

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; pc_cur = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    resp_en = 1'b1;

    // Reset dominates a redirect, then streaming with a 1-cycle memory.
    vecs.push_back(v(1, 1, 64'hDEADBEEF_DEADBEEF, 1, 1, 1, 0, 64'h0,  0, 64'h0));
    vecs.push_back(v(1, 0, 64'h0, 1, 1, 1, 0, 64'h0,  0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h4,  0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h8,  0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 0, 64'h8,  1, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'hC,  1, 64'h4));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h10, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 0, 64'h10, 1, 64'h8));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h14, 1, 64'hC));
    // Decode backpressure: full at 2, pop at full does not unblock the request that cycle.
    vecs.push_back(v(1, 0, 64'h0, 0, 1, 1, 0, 64'h0,  0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 0, 1, 1, 1, 64'h4,  0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 0, 1, 1, 1, 64'h8,  0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 0, 1, 1, 0, 64'h8,  1, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 0, 64'h8,  1, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'hC,  1, 64'h4));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h10, 0, 64'h0));
    // Redirect with two in flight: drain both stale responses.
    vecs.push_back(v(1, 0, 64'h0, 1, 1, 0, 0, 64'h0,  0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 0, 1, 64'h4,  0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 0, 1, 64'h8,  0, 64'h0));
    vecs.push_back(v(0, 1, 64'h8000_0002, 1, 1, 0, 0, 64'h8000_0000, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 0, 64'h8000_0000, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 0, 64'h8000_0000, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h8000_0004, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h8000_0008, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 0, 64'h8000_0008, 1, 64'h8000_0000));
    // Stalled memory keeps the request stable; redirect coincides with the only response.
    vecs.push_back(v(1, 0, 64'h0, 1, 1, 0, 0, 64'h0,   0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 0, 1, 64'h4,   0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 0, 0, 1, 64'h4,   0, 64'h0));
    vecs.push_back(v(0, 1, 64'h100, 1, 1, 1, 0, 64'h100, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h104, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h108, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 0, 64'h108, 1, 64'h100));
    // PC wrap at the top of the address space.
    vecs.push_back(v(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h104));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h0, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 1, 64'h4, 0, 64'h0));
    vecs.push_back(v(0, 0, 64'h0, 1, 1, 1, 0, 64'h4, 1, 64'hFFFF_FFFF_FFFF_FFFC));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; redirect_valid = vecs[i].redir; redirect_target = vecs[i].tgt;
      inst_ready = vecs[i].irdy; imem_req_ready = vecs[i].mrdy; resp_en = vecs[i].men;
      step();
      chk("vec_req_valid", i, 64'(s_rv), 64'(vecs[i].exp_rv));
      chk("vec_pc_next", i, s_pn, vecs[i].exp_pn);
      chk("vec_inst_valid", i, 64'(s_iv), 64'(vecs[i].exp_iv));
      if (vecs[i].exp_iv) chk("vec_inst_pc", i, s_ipc, vecs[i].exp_ipc);
    end

    for (int n = 0; n < 4000; n++) begin
      reset          = ($urandom_range(0, 249) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_target = {$urandom, $urandom};
        1:       redirect_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: redirect_target = 64'($urandom_range(0, 255));
      endcase
      inst_ready     = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      resp_en        = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
